// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Two-digit BCD countdown timer. A load strobe captures the 2-bit tens and
// units presets (range 00..33). After `start`, the value counts down one unit
// per `tick`, borrowing from the tens digit when the units digit is 0. The
// timer can be paused and resumed. On reaching 00 it pulses `done` once and
// holds `alarm` high for ALARM_TICKS ticks.
//
// Parameters:
//   ALARM_TICKS  number of ticks `alarm` stays high after expiry (1..15)
//
// Ports:
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   pls      in   preset load strobe
//   ps_ds    in   [1:0] preset tens digit
//   ps_us    in   [1:0] preset units digit
//   start    in   start / resume request (one cycle)
//   stop     in   pause / cancel request (one cycle)
//   tick     in   time-base enable (one cycle per count)
//   ds       out  [3:0] current tens digit, BCD
//   us       out  [3:0] current units digit, BCD
//   running  out  high while counting
//   done     out  one-cycle pulse on the first cycle of expiry
//   alarm    out  high while the expiry alarm is active
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pls,
    input  logic [1:0] ps_ds,
    input  logic [1:0] ps_us,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    output logic [3:0] ds,
    output logic [3:0] us,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [2:0] {
        StIdle,
        StReady,
        StRun,
        StPause,
        StDone
    } state_e;

    // Counter value at which the final alarm tick is taken.
    localparam logic [3:0] AlarmLast = 4'(ALARM_TICKS - 1);

    state_e     state_q, state_d;
    logic [3:0] ds_q, ds_d;
    logic [3:0] us_q, us_d;
    logic [3:0] acnt_q, acnt_d;
    logic       done_q, done_d;

    logic [3:0] load_ds;
    logic [3:0] load_us;
    logic       is_zero;
    logic       is_one;

    assign load_ds = {2'b00, ps_ds};
    assign load_us = {2'b00, ps_us};
    assign is_zero = (ds_q == 4'd0) && (us_q == 4'd0);
    assign is_one  = (ds_q == 4'd0) && (us_q == 4'd1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ds_q    <= 4'd0;
            us_q    <= 4'd0;
            acnt_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ds_q    <= ds_d;
            us_q    <= us_d;
            acnt_q  <= acnt_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // Priority within a cycle: pls (except in RUN) > stop > start > tick.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ds_d    = ds_q;
        us_d    = us_q;
        acnt_d  = acnt_q;

        unique case (state_q)
            StIdle: begin
                if (pls) begin
                    ds_d    = load_ds;
                    us_d    = load_us;
                    state_d = StReady;
                end
            end

            StReady: begin
                if (pls) begin
                    ds_d = load_ds;
                    us_d = load_us;
                end else if (stop) begin
                    ds_d    = 4'd0;
                    us_d    = 4'd0;
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                if (stop) begin
                    state_d = StPause;
                end else if (is_zero) begin
                    // Started from 00: expire without waiting for a tick.
                    state_d = StDone;
                    acnt_d  = 4'd0;
                end else if (tick) begin
                    if (us_q != 4'd0) begin
                        us_d = us_q - 4'd1;
                    end else begin
                        ds_d = ds_q - 4'd1;
                        us_d = 4'd9;
                    end
                    if (is_one) begin
                        state_d = StDone;
                        acnt_d  = 4'd0;
                    end
                end
            end

            StPause: begin
                if (pls) begin
                    ds_d    = load_ds;
                    us_d    = load_us;
                    state_d = StReady;
                end else if (stop) begin
                    ds_d    = 4'd0;
                    us_d    = 4'd0;
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                end
            end

            StDone: begin
                if (pls) begin
                    ds_d    = load_ds;
                    us_d    = load_us;
                    state_d = StReady;
                end else if (stop) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (acnt_q == AlarmLast) begin
                        state_d = StIdle;
                    end else begin
                        acnt_d = acnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Pulse only on the transition into DONE.
        done_d = (state_d == StDone) && (state_q != StDone);
    end

    // -----------------------------------------------------------------------
    // Outputs: all derived from registers only
    // -----------------------------------------------------------------------
    always_comb begin
        ds      = ds_q;
        us      = us_q;
        done    = done_q;
        running = (state_q == StRun);
        alarm   = (state_q == StDone);
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int ATicks = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pls = 1'b0;
    logic [1:0] ps_ds = 2'd0;
    logic [1:0] ps_us = 2'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] ds;
    logic [3:0] us;
    logic       running;
    logic       done;
    logic       alarm;

    always #5 clk = ~clk;

    countdown_timer #(
        .ALARM_TICKS(ATicks)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pls    (pls),
        .ps_ds  (ps_ds),
        .ps_us  (ps_us),
        .start  (start),
        .stop   (stop),
        .tick   (tick),
        .ds     (ds),
        .us     (us),
        .running(running),
        .done   (done),
        .alarm  (alarm)
    );

    // Reference model: remaining time as a plain integer 0..33.
    localparam int MIdle  = 0;
    localparam int MReady = 1;
    localparam int MRun   = 2;
    localparam int MPause = 3;
    localparam int MDone  = 4;

    int m_mode = MIdle;
    int m_val  = 0;
    int m_acnt = 0;
    int m_done = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int prev;
        prev = m_mode;
        if (rst) begin
            m_mode = MIdle;
            m_val  = 0;
            m_acnt = 0;
        end else begin
            case (m_mode)
                MIdle: if (pls) begin
                    m_val  = 10 * int'(ps_ds) + int'(ps_us);
                    m_mode = MReady;
                end
                MReady, MPause: begin
                    if (pls) begin
                        m_val  = 10 * int'(ps_ds) + int'(ps_us);
                        m_mode = MReady;
                    end else if (stop) begin
                        m_val  = 0;
                        m_mode = MIdle;
                    end else if (start) begin
                        m_mode = MRun;
                    end
                end
                MRun: begin
                    if (stop) m_mode = MPause;
                    else if (m_val == 0) m_mode = MDone;
                    else if (tick) begin
                        m_val = m_val - 1;
                        if (m_val == 0) m_mode = MDone;
                    end
                    if (m_mode == MDone) m_acnt = 0;
                end
                MDone: begin
                    if (pls) begin
                        m_val  = 10 * int'(ps_ds) + int'(ps_us);
                        m_mode = MReady;
                    end else if (stop) begin
                        m_mode = MIdle;
                    end else if (tick) begin
                        m_acnt = m_acnt + 1;
                        if (m_acnt == ATicks) m_mode = MIdle;
                    end
                end
                default: m_mode = MIdle;
            endcase
        end
        m_done = (!rst && m_mode == MDone && prev != MDone) ? 1 : 0;
    endtask

    task automatic step(input bit r, input bit p, input int pd, input int pu,
                        input bit sa, input bit so, input bit t);
        rst   = r;
        pls   = p;
        ps_ds = 2'(pd);
        ps_us = 2'(pu);
        start = sa;
        stop  = so;
        tick  = t;
        @(posedge clk);
        model_step();
        #1;
        check("ds", 32'(ds), 32'(m_val / 10));
        check("us", 32'(us), 32'(m_val % 10));
        check("running", 32'(running), 32'(m_mode == MRun));
        check("alarm", 32'(alarm), 32'(m_mode == MDone));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset then load 21
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_ds", 32'(ds), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        step(0, 1, 2, 1, 0, 0, 0);
        check("load21", {24'd0, ds, us}, 32'h21);

        // Borrow and expiry, then alarm timeout
        step(0, 0, 0, 0, 1, 0, 0);
        ticks(11);
        check("borrow_10", {24'd0, ds, us}, 32'h10);
        ticks(1);
        check("borrow_09", {24'd0, ds, us}, 32'h09);
        ticks(9);
        check("expiry_done", 32'(done), 32'd1);
        check("expiry_alarm", 32'(alarm), 32'd1);
        ticks(4);
        check("alarm_hold", 32'(alarm), 32'd1);
        ticks(1);
        check("alarm_timeout", 32'(alarm), 32'd0);

        // Pause and resume
        step(0, 1, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        ticks(2);
        step(0, 0, 0, 0, 0, 1, 1);
        check("pause_hold", {24'd0, ds, us}, 32'h11);
        check("pause_run", 32'(running), 32'd0);
        ticks(3);
        step(0, 0, 0, 0, 1, 0, 0);
        ticks(1);
        check("resume_tick", {24'd0, ds, us}, 32'h10);

        // Zero preset
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        check("zero_done", 32'(done), 32'd1);

        // Alarm cancel, then reload during alarm
        step(0, 0, 0, 0, 0, 1, 0);
        check("cancel_alarm", 32'(alarm), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 1, 3, 3, 0, 0, 0);
        check("reload_33", {24'd0, ds, us}, 32'h33);

        // Reset mid-count at 12 with tick, then load priority over start
        step(0, 0, 0, 0, 1, 0, 0);
        ticks(21);
        check("at_12", {24'd0, ds, us}, 32'h12);
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 2, 0, 0, 0);
        step(0, 1, 2, 3, 1, 0, 0);
        check("pls_beats_start", 32'(running), 32'd0);
        check("pls_beats_start_val", {24'd0, ds, us}, 32'h23);

        // Randomised stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 11) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 13) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Two-digit BCD countdown that consumes the preset digits produced by the preset decoder. On the load strobe it captures the 2-bit tens and units presets, then counts down one unit per `tick` after `start`. It supports pause and resume, and raises a timed alarm on reaching 00. It drives the display and buzzer stages downstream.

## Interface
- `ALARM_TICKS`, default 5: number of `tick` pulses for which `alarm` stays high after expiry (1..15).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pls`  in  1  load strobe; the same signal that qualifies the preset decoder outputs.
- `ps_ds`  in  2  preset tens digit from the preset decoder.
- `ps_us`  in  2  preset units digit from the preset decoder.
- `start`  in  1  one-cycle request to start or resume counting.
- `stop`  in  1  one-cycle request to pause counting or cancel the alarm.
- `tick`  in  1  one-cycle time-base enable (nominally 1 Hz).
- `ds`  out  4  current tens digit, BCD.
- `us`  out  4  current units digit, BCD.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on expiry.
- `alarm`  out  1  high in DONE.

## Operation
- States: IDLE, READY, RUN, PAUSE, DONE. All outputs are registered.
- Load: `ds <= {2'b00, ps_ds}`, `us <= {2'b00, ps_us}`. Loadable range is 00..33; digit values never exceed 9.
- IDLE:
  - `pls` -> load, go READY.
  - `start` and `stop` are ignored.
- READY:
  - `pls` -> reload, stay READY.
  - `start` (without `pls`) -> RUN.
  - `stop` -> IDLE, digits cleared to 00.
- RUN:
  - `stop` -> PAUSE; digits hold.
  - Otherwise, on `tick`:
    - if `us != 0`, `us <= us - 1`;
    - else if `ds != 0`, `ds <= ds - 1` and `us <= 9`.
  - If the post-decrement value is 00 -> DONE, with a `done` pulse.
  - Entering RUN with digits 00 -> DONE on the next cycle, independent of `tick`.
  - `pls` is ignored.
- PAUSE:
  - `start` -> RUN.
  - `pls` -> reload, go READY.
  - `stop` -> IDLE, digits cleared.
- DONE:
  - `alarm` = 1 and an internal alarm counter starts at 0.
  - Each `tick` increments the counter; when it reaches `ALARM_TICKS` -> IDLE.
  - `stop` -> IDLE immediately.
  - `pls` -> load, go READY.
  - `start` is ignored.
- Priority within a cycle: `rst` > `pls` (except in RUN) > `stop` > `start` > `tick`.
- Boundaries:
  - `ds`=1, `us`=0 plus `tick` -> 09 (borrow).
  - 01 plus `tick` -> 00 and DONE.
  - Digits never wrap below 00.
  - In RUN, `tick` together with `stop` -> PAUSE with no decrement.

## Timing
- Reset values: state IDLE, `ds`=0, `us`=0, `running`=0, `done`=0, `alarm`=0, alarm counter 0.
- Latency:
  - Input sampled at edge n -> outputs and state valid after edge n (one cycle).
  - No combinational path from inputs to outputs.
- `running` and `alarm` are decoded from the registered state; both are valid in the same cycle the state is entered.
- `done`:
  - Asserted for exactly one cycle, the first cycle in DONE.
  - It coincides with `ds`/`us` first reading 00.
- `rst` asserted mid-count or mid-alarm: the next cycle reaches the full reset values; the `tick` and `pls` of that cycle are discarded.
- `tick` may be asserted on consecutive cycles; each asserted cycle counts once.
- Inputs are synchronous to `clk`. Synchronising and debouncing buttons is handled upstream.

## Test plan
- Reset then load: `rst` for 2 cycles, then `pls` with `ps_ds`=2, `ps_us`=1.
  - Next cycle: `ds`=2, `us`=1, state READY, `running`=0.
- Borrow and expiry: from 21, `start`, then 21 ticks.
  - Digits pass 20, 19, … 10, 09, … 01, 00.
  - `done` pulses once, exactly on the 21st tick's following cycle.
  - `alarm`=1.
  - After 5 further ticks, `alarm`=0 and state IDLE.
- Pause and resume: from 13 in RUN, tick to 11, then `stop` asserted together with `tick`.
  - Digits stay 11 and `running`=0.
  - Ticks during PAUSE do not change the digits.
  - `start` resumes; the next tick gives 10.
- Zero preset: `pls` with both presets 0, then `start`.
  - RUN for one cycle, then DONE with a `done` pulse and digits 00, no tick needed.
- Alarm cancel and reload during alarm:
  - In DONE, `stop` -> IDLE next cycle, `alarm`=0.
  - Repeat the run; in DONE assert `pls` with `ps_ds`=3, `ps_us`=3 -> READY, digits 33, `alarm`=0.
- Reset mid-operation and load priority:
  - `rst` asserted during RUN at 12 together with `tick` -> next cycle all outputs at reset values.
  - In READY, `pls` together with `start` -> reload wins, state stays READY.
